cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_if.sv | 44 ++++
 rtl/cache_controller.sv | 176 +++++++++++++++++
 tb/tb_cache_controller.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Request, response and storage-port signal bundle for cache_controller.
// slave is the controller's view; master is the requester/storage side.
interface cache_controller_if #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [KEY_WIDTH-1:0]   req_key;
    logic [VALUE_WIDTH-1:0] req_value;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [1:0]             resp_status;
    logic [VALUE_WIDTH-1:0] resp_value;

    logic                   mem_write;
    logic                   mem_select_by_index;
    logic                   mem_delete;
    logic [KEY_WIDTH-1:0]   mem_key;
    logic [VALUE_WIDTH-1:0] mem_value;
    logic [NUM_ENTRIES-1:0] mem_index;

    logic [VALUE_WIDTH-1:0] mem_value_in;
    logic [NUM_ENTRIES-1:0] mem_index_in;
    logic                   mem_hit;
    logic [NUM_ENTRIES-1:0] mem_used;

    modport slave (
        input  req_valid, req_op, req_key, req_value, resp_ready,
               mem_value_in, mem_index_in, mem_hit, mem_used,
        output req_ready, resp_valid, resp_status, resp_value,
               mem_write, mem_select_by_index, mem_delete, mem_key, mem_value, mem_index
    );

    modport master (
        output req_valid, req_op, req_key, req_value, resp_ready,
               mem_value_in, mem_index_in, mem_hit, mem_used,
        input  req_ready, resp_valid, resp_status, resp_value,
               mem_write, mem_select_by_index, mem_delete, mem_key, mem_value, mem_index
    );
endinterface

// File: rtl/cache_controller.sv
// Key/value cache controller: GET/PUT/DEL against an external associative store.
// Define CACHE_CTRL_EVICT_EN to evict round-robin on a PUT miss when the store is full.
module cache_controller #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64
) (
    input logic               clk,
    input logic               rst_n,
    cache_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WRITE, DELETE, RESP} state_t;

    localparam logic [1:0] OP_GET  = 2'b00;
    localparam logic [1:0] OP_PUT  = 2'b01;
    localparam logic [1:0] OP_RSV  = 2'b11;
    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_MISS = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;
    localparam logic [NUM_ENTRIES-1:0] ONE = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [1:0]             op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] value_q;
    logic [NUM_ENTRIES-1:0] target_q, target_d;
    logic [1:0]             status_q, status_d;
    logic [VALUE_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_ENTRIES-1:0] used_plus1;
    logic [NUM_ENTRIES-1:0] free_oh;
    logic                   full;

    // Lowest clear bit of mem_used as one-hot; zero when every cell is occupied.
    assign used_plus1 = bus.mem_used + ONE;
    assign free_oh    = ~bus.mem_used & used_plus1;
    assign full       = &bus.mem_used;

`ifdef CACHE_CTRL_EVICT_EN
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    logic [IDX_W-1:0] victim_q;
    logic             evict_q, evict_d;
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        status_d = status_q;
        rdata_d  = rdata_q;
`ifdef CACHE_CTRL_EVICT_EN
        evict_d  = evict_q;
`endif
        bus.req_ready           = 1'b0;
        bus.resp_valid          = 1'b0;
        bus.resp_status         = ST_OK;
        bus.resp_value          = '0;
        bus.mem_write           = 1'b0;
        bus.mem_select_by_index = 1'b0;
        bus.mem_delete          = 1'b0;
        bus.mem_key             = '0;
        bus.mem_value           = '0;
        bus.mem_index           = '0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                bus.mem_key = key_q;
                status_d    = ST_OK;
                rdata_d     = '0;
                target_d    = '0;
`ifdef CACHE_CTRL_EVICT_EN
                evict_d     = 1'b0;
`endif
                if (key_q == '0 || op_q == OP_RSV) begin
                    status_d = ST_ERR;
                    state_d  = RESP;
                end else if (op_q == OP_GET) begin
                    state_d = RESP;
                    if (bus.mem_hit) rdata_d  = bus.mem_value_in;
                    else             status_d = ST_MISS;
                end else if (op_q == OP_PUT) begin
                    state_d = WRITE;
                    if (bus.mem_hit) begin
                        target_d = bus.mem_index_in;
                    end else if (!full) begin
                        target_d = free_oh;
                    end else begin
`ifdef CACHE_CTRL_EVICT_EN
                        target_d = ONE << victim_q;
                        evict_d  = 1'b1;
`else
                        status_d = ST_FULL;
                        state_d  = RESP;
`endif
                    end
                end else begin
                    if (bus.mem_hit) begin
                        target_d = bus.mem_index_in;
                        state_d  = DELETE;
                    end else begin
                        status_d = ST_MISS;
                        state_d  = RESP;
                    end
                end
            end
            WRITE: begin
                bus.mem_write           = 1'b1;
                bus.mem_select_by_index = 1'b1;
                bus.mem_index           = target_q;
                bus.mem_key             = key_q;
                bus.mem_value           = value_q;
                state_d                 = RESP;
            end
            DELETE: begin
                bus.mem_delete          = 1'b1;
                bus.mem_select_by_index = 1'b1;
                bus.mem_index           = target_q;
                bus.mem_key             = key_q;
                state_d                 = RESP;
            end
            RESP: begin
                bus.resp_valid  = 1'b1;
                bus.resp_status = status_q;
                bus.resp_value  = rdata_q;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            key_q    <= '0;
            value_q  <= '0;
            target_q <= '0;
            status_q <= ST_OK;
            rdata_q  <= '0;
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                op_q    <= bus.req_op;
                key_q   <= bus.req_key;
                value_q <= bus.req_value;
            end
            target_q <= target_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef CACHE_CTRL_EVICT_EN
    // Pointer advances only when an eviction write actually completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_q <= '0;
            evict_q  <= 1'b0;
        end else begin
            evict_q <= evict_d;
            if (state_q == WRITE && evict_q)
                victim_q <= (victim_q == LAST_IDX) ? '0 : victim_q + IDX_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural associative store model.
module tb_cache_controller;
    localparam int NE = 16;
    localparam int KW = 16;
    localparam int VW = 64;
    localparam logic [1:0] GET = 2'b00, PUT = 2'b01, DEL = 2'b10, RSV = 2'b11;
    localparam logic [1:0] OK = 2'b00, MISS = 2'b01, FULLST = 2'b10, ERR = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus();

    cache_controller #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [KW-1:0] st_key [NE];
    logic [VW-1:0] st_val [NE];
    logic [NE-1:0] st_used = '0;
    int            wr_cnt = 0, del_cnt = 0, bad_cnt = 0;
    logic [NE-1:0] wr_idx = '0, del_idx = '0;

    assign bus.mem_used = st_used;

    always_comb begin
        bus.mem_hit      = 1'b0;
        bus.mem_index_in = '0;
        bus.mem_value_in = '0;
        for (int i = 0; i < NE; i++) begin
            if (st_used[i] && st_key[i] == bus.mem_key) begin
                bus.mem_hit         = 1'b1;
                bus.mem_index_in[i] = 1'b1;
                bus.mem_value_in    = st_val[i];
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write && bus.mem_delete) bad_cnt++;
        if (bus.mem_select_by_index && !(bus.mem_write || bus.mem_delete)) bad_cnt++;
        if (bus.resp_valid && (bus.mem_write || bus.mem_delete || bus.mem_select_by_index ||
                               bus.mem_key != '0 || bus.mem_index != '0)) bad_cnt++;
        if (bus.mem_write) begin
            wr_cnt++;
            wr_idx = bus.mem_index;
            for (int i = 0; i < NE; i++)
                if (bus.mem_index[i]) begin
                    st_used[i] = 1'b1;
                    st_key[i]  = bus.mem_key;
                    st_val[i]  = bus.mem_value;
                end
        end
        if (bus.mem_delete) begin
            del_cnt++;
            del_idx = bus.mem_index;
            for (int i = 0; i < NE; i++)
                if (bus.mem_index[i]) st_used[i] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                          output logic [1:0] st, output logic [VW-1:0] rv, output int lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_key   = key;
        bus.req_value = val;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (bus.resp_valid) break;
        end
        check("resp_valid_seen", 64'(bus.resp_valid), 64'(1));
        st = bus.resp_status;
        rv = bus.resp_value;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [1:0] op, input logic [KW-1:0] key,
                       input logic [VW-1:0] val, input logic [1:0] exp_st,
                       input logic [VW-1:0] exp_val, input int exp_lat);
        logic [1:0]    st;
        logic [VW-1:0] rv;
        int            lat;
        do_req(op, key, val, st, rv, lat);
        check({tag, "_status"}, 64'(st), 64'(exp_st));
        check({tag, "_value"}, rv, exp_val);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int            w0, d0;
        logic [1:0]    st0;
        logic [VW-1:0] v0;

        bus.req_valid  = 1'b0;
        bus.req_op     = GET;
        bus.req_key    = '0;
        bus.req_value  = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_resp_status", 64'(bus.resp_status), 64'(0));
        check("rst_resp_value", bus.resp_value, 64'(0));
        check("rst_mem_strobes", 64'({bus.mem_write, bus.mem_delete, bus.mem_select_by_index}), 64'(0));
        check("rst_mem_index", 64'(bus.mem_index), 64'(0));
        check("rst_mem_key", 64'(bus.mem_key), 64'(0));
        rst_n = 1'b1;

        w0 = wr_cnt;
        txn("put1_aa", PUT, 16'h0001, 64'hAA, OK, 64'h0, 3);
        check("put1_aa_wrcnt", 64'(wr_cnt - w0), 64'(1));
        check("put1_aa_idx", 64'(wr_idx), 64'h0001);
        txn("get1", GET, 16'h0001, 64'h0, OK, 64'hAA, 2);
        txn("get2_miss", GET, 16'h0002, 64'h0, MISS, 64'h0, 2);

        w0 = wr_cnt;
        txn("put1_bb", PUT, 16'h0001, 64'hBB, OK, 64'h0, 3);
        check("put1_bb_idx", 64'(wr_idx), 64'h0001);
        check("put1_bb_used", 64'(st_used), 64'h0001);
        txn("get1_bb", GET, 16'h0001, 64'h0, OK, 64'hBB, 2);

        d0 = del_cnt;
        txn("del1", DEL, 16'h0001, 64'h0, OK, 64'h0, 3);
        check("del1_cnt", 64'(del_cnt - d0), 64'(1));
        check("del1_idx", 64'(del_idx), 64'h0001);
        txn("del1_again", DEL, 16'h0001, 64'h0, MISS, 64'h0, 2);
        check("del1_again_cnt", 64'(del_cnt - d0), 64'(1));
        txn("put5_realloc", PUT, 16'h0005, 64'h55, OK, 64'h0, 3);
        check("put5_idx", 64'(wr_idx), 64'h0001);

        w0 = wr_cnt;
        txn("get_key0", GET, 16'h0000, 64'h0, ERR, 64'h0, 2);
        txn("put_key0", PUT, 16'h0000, 64'h1, ERR, 64'h0, 2);
        txn("op_rsv", RSV, 16'h0003, 64'h1, ERR, 64'h0, 2);
        check("err_no_write", 64'(wr_cnt - w0), 64'(0));

        // Response back-pressure: outputs must hold while resp_ready stays low.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = GET; bus.req_key = 16'h0005; bus.req_value = '0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.resp_valid) break;
        end
        st0 = bus.resp_status;
        v0  = bus.resp_value;
        check("hold_first_status", 64'(st0), 64'(OK));
        check("hold_first_value", v0, 64'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", 64'(bus.resp_valid), 64'(1));
            check("hold_status", 64'(bus.resp_status), 64'(OK));
            check("hold_value", bus.resp_value, 64'h55);
            check("hold_req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        check("after_hold_req_ready", 64'(bus.req_ready), 64'(1));

        // Reset asserted in the middle of a WRITE cycle.
        w0 = wr_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = PUT; bus.req_key = 16'h0007; bus.req_value = 64'h77;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("midwr_strobe", 64'(bus.mem_write), 64'(1));
        check("midwr_index", 64'(bus.mem_index), 64'h0002);
        rst_n = 1'b0;
        #1;
        check("midwr_rst_write", 64'(bus.mem_write), 64'(0));
        check("midwr_rst_index", 64'(bus.mem_index), 64'(0));
        check("midwr_rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("midwr_rst_req_ready", 64'(bus.req_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midwr_no_resp", 64'(bus.resp_valid), 64'(0));
        check("midwr_no_write", 64'(wr_cnt - w0), 64'(0));
        txn("get7_aborted", GET, 16'h0007, 64'h0, MISS, 64'h0, 2);
        txn("put7", PUT, 16'h0007, 64'h77, OK, 64'h0, 3);
        check("put7_idx", 64'(wr_idx), 64'h0002);

        for (int k = 1; k <= 16; k++)
            txn("fill", PUT, KW'(k), VW'(k), OK, 64'h0, 3);
        check("fill_used", 64'(st_used), 64'hFFFF);

        w0 = wr_cnt;
`ifdef CACHE_CTRL_EVICT_EN
        txn("put17_evict", PUT, 16'd17, 64'h117, OK, 64'h0, 3);
        check("put17_idx", 64'(wr_idx), 64'h0001);
        txn("put18_evict", PUT, 16'd18, 64'h118, OK, 64'h0, 3);
        check("put18_idx", 64'(wr_idx), 64'h0002);
        check("evict_wrcnt", 64'(wr_cnt - w0), 64'(2));
        txn("get17", GET, 16'd17, 64'h0, OK, 64'h117, 2);
        txn("get5_evicted", GET, 16'd5, 64'h0, MISS, 64'h0, 2);
`else
        txn("put17_full", PUT, 16'd17, 64'h117, FULLST, 64'h0, 2);
        txn("put18_full", PUT, 16'd18, 64'h118, FULLST, 64'h0, 2);
        check("full_no_write", 64'(wr_cnt - w0), 64'(0));
        txn("get16", GET, 16'd16, 64'h0, OK, 64'd16, 2);
        txn("get17_miss", GET, 16'd17, 64'h0, MISS, 64'h0, 2);
`endif
        check("mem_protocol_violations", 64'(bad_cnt), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
